path_stack_queue: RTL and testbench

- Responder for the rat controller's direction-history commands (push/pop during search; ld_q/rst_frontq/dequeue during run replay).
- Stores 2-bit move directions in a LIFO during maze search.
- On finish, snapshots the stack as a FIFO path and replays it in order from start cell to goal.
- Sits beside the controller and datapath in the IntelligentRat top level.

---
 rtl/path_stack_queue_pkg.sv | 13 +
 rtl/path_stack_queue_dir_ram.sv | 28 ++
 rtl/path_stack_queue.sv | 143 ++++++++++++++
 tb/tb_path_stack_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/path_stack_queue_pkg.sv
// Shared rat definitions: move direction encoding (common with the controller) and default path depth.
package path_stack_queue_pkg;

    localparam int unsigned DEFAULT_DEPTH = 256;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

endpackage

// File: rtl/path_stack_queue_dir_ram.sv
// DEPTH x 2-bit direction store: one synchronous write port, two asynchronous read ports (stack top, queue front).
module path_stack_queue_dir_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] top_addr,
    output logic [1:0]    top_data,
    input  logic [AW-1:0] front_addr,
    output logic [1:0]    front_data
);

    logic [1:0] mem [DEPTH];

    // Contents are deliberately never cleared; only pointers are reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign top_data   = mem[top_addr];
    assign front_data = mem[front_addr];

endmodule

// File: rtl/path_stack_queue.sv
// Direction history: LIFO during search, snapshotted FIFO replay during run.
// Optional path_len / max_depth outputs are enabled by defining PATH_STACK_LEN_EN.
module path_stack_queue
    import path_stack_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [1:0]                  push_val,
    input  logic                        pop,
    output logic [1:0]                  pop_val,
    output logic                        empty,
    output logic                        full,
    output logic                        overflow,
    input  logic                        ld_q,
    input  logic                        rst_frontq,
    input  logic                        dequeue,
    output logic [1:0]                  deq_val,
    output logic                        deq_valid,
`ifdef PATH_STACK_LEN_EN
    output logic [$clog2(DEPTH):0]      path_len,
    output logic [$clog2(DEPTH):0]      max_depth,
`endif
    output logic                        finishq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] sp_q, sp_d;
    logic [PW-1:0] qlen_q, qlen_d;
    logic [PW-1:0] front_q, front_d;
    logic [1:0]    pop_val_q, pop_val_d;
    logic [1:0]    deq_val_q, deq_val_d;
    logic          deq_valid_q, deq_valid_d;
    logic          overflow_q, overflow_d;
`ifdef PATH_STACK_LEN_EN
    logic [PW-1:0] max_depth_q, max_depth_d;
`endif

    logic          we;
    logic [1:0]    top_data;
    logic [1:0]    front_data;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == PW'(DEPTH));
    assign finishq = (front_q == qlen_q);

    path_stack_queue_dir_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dir_ram (
        .clk        (clk),
        .we         (we),
        .waddr      (AW'(sp_q)),
        .wdata      (push_val),
        .top_addr   (AW'(sp_q - PW'(1))),
        .top_data   (top_data),
        .front_addr (AW'(front_q)),
        .front_data (front_data)
    );

    // Next-state: push beats pop; a rewind (ld_q / rst_frontq) beats dequeue.
    always_comb begin
        sp_d        = sp_q;
        qlen_d      = qlen_q;
        front_d     = front_q;
        pop_val_d   = pop_val_q;
        deq_val_d   = deq_val_q;
        deq_valid_d = 1'b0;
        overflow_d  = overflow_q;
        we          = 1'b0;
`ifdef PATH_STACK_LEN_EN
        max_depth_d = max_depth_q;
`endif

        if (push) begin
            if (!full) begin
                we   = !rst;
                sp_d = sp_q + PW'(1);
`ifdef PATH_STACK_LEN_EN
                if (sp_d > max_depth_q) begin
                    max_depth_d = sp_d;
                end
`endif
            end else begin
                overflow_d = 1'b1;
            end
        end else if (pop && !empty) begin
            pop_val_d = top_data;
            sp_d      = sp_q - PW'(1);
        end

        if (ld_q) begin
            qlen_d  = sp_q;
            front_d = '0;
        end else if (rst_frontq) begin
            front_d = '0;
        end else if (dequeue && (front_q < qlen_q)) begin
            deq_val_d   = front_data;
            front_d     = front_q + PW'(1);
            deq_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q        <= '0;
            qlen_q      <= '0;
            front_q     <= '0;
            pop_val_q   <= 2'b00;
            deq_val_q   <= 2'b00;
            deq_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef PATH_STACK_LEN_EN
            max_depth_q <= '0;
`endif
        end else begin
            sp_q        <= sp_d;
            qlen_q      <= qlen_d;
            front_q     <= front_d;
            pop_val_q   <= pop_val_d;
            deq_val_q   <= deq_val_d;
            deq_valid_q <= deq_valid_d;
            overflow_q  <= overflow_d;
`ifdef PATH_STACK_LEN_EN
            max_depth_q <= max_depth_d;
`endif
        end
    end

    assign pop_val   = pop_val_q;
    assign deq_val   = deq_val_q;
    assign deq_valid = deq_valid_q;
    assign overflow  = overflow_q;
`ifdef PATH_STACK_LEN_EN
    assign path_len  = qlen_q;
    assign max_depth = max_depth_q;
`endif

endmodule

// File: tb/tb_path_stack_queue.sv
// Directed self-checking bench for path_stack_queue (DEPTH=8); covers PATH_STACK_LEN_EN when defined.
module tb_path_stack_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [1:0]    push_val = 2'b00;
    logic          pop = 1'b0;
    logic [1:0]    pop_val;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          ld_q = 1'b0;
    logic          rst_frontq = 1'b0;
    logic          dequeue = 1'b0;
    logic [1:0]    deq_val;
    logic          deq_valid;
    logic          finishq;
`ifdef PATH_STACK_LEN_EN
    logic [PW-1:0] path_len;
    logic [PW-1:0] max_depth;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    path_stack_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_val   (push_val),
        .pop        (pop),
        .pop_val    (pop_val),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .ld_q       (ld_q),
        .rst_frontq (rst_frontq),
        .dequeue    (dequeue),
        .deq_val    (deq_val),
        .deq_valid  (deq_valid),
`ifdef PATH_STACK_LEN_EN
        .path_len   (path_len),
        .max_depth  (max_depth),
`endif
        .finishq    (finishq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [1:0] v);
        push = 1'b1; push_val = v;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (pop_val !== 2'b00)  begin errors++; $display("FAIL reset_pop_val got=%b exp=00", pop_val); end
        checks++; if (deq_val !== 2'b00)  begin errors++; $display("FAIL reset_deq_val got=%b exp=00", deq_val); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
        checks++; if (finishq !== 1'b1)   begin errors++; $display("FAIL reset_finishq got=%b exp=1", finishq); end
    endtask

    task automatic test_push_pop();
        logic [1:0] exp_pop [3] = '{2'b11, 2'b10, 2'b01};
        do_push(2'b01);
        do_push(2'b10);
        do_push(2'b11);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pp_empty_after_push got=%b exp=0", empty); end
        for (int i = 0; i < 3; i++) begin
            do_pop();
            checks++;
            if (pop_val !== exp_pop[i]) begin
                errors++; $display("FAIL pp_pop_val[%0d] got=%b exp=%b", i, pop_val, exp_pop[i]);
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty_after_pops got=%b exp=1", empty); end
    endtask

    task automatic test_pop_empty();
        do_pop();
        checks++; if (pop_val !== 2'b01) begin errors++; $display("FAIL pe_pop_val_hold got=%b exp=01", pop_val); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL pe_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL pe_no_wrap_full got=%b exp=0", full); end
        // One push then one pop must return to empty if sp stayed at 0.
        do_push(2'b10);
        do_pop();
        checks++; if (pop_val !== 2'b10) begin errors++; $display("FAIL pe_repush_pop got=%b exp=10", pop_val); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL pe_repush_empty got=%b exp=1", empty); end
    endtask

    task automatic test_replay();
        logic [1:0] exp_deq [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        do_push(2'b00);
        do_push(2'b01);
        do_push(2'b10);
        do_push(2'b11);
        ld_q = 1'b1;
        tick();
        ld_q = 1'b0;
        checks++; if (finishq !== 1'b0) begin errors++; $display("FAIL rp_finishq_after_ld got=%b exp=0", finishq); end
        dequeue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (deq_val !== exp_deq[i] || deq_valid !== 1'b1) begin
                errors++; $display("FAIL rp_deq[%0d] got=%b/%b exp=%b/1", i, deq_val, deq_valid, exp_deq[i]);
            end
        end
        checks++; if (finishq !== 1'b1) begin errors++; $display("FAIL rp_finishq_after_4 got=%b exp=1", finishq); end
        tick();
        dequeue = 1'b0;
        checks++;
        if (deq_valid !== 1'b0 || deq_val !== 2'b11) begin
            errors++; $display("FAIL rp_deq5 got=%b/%b exp=11/0", deq_val, deq_valid);
        end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL rp_stack_kept got=%b exp=0", empty); end
    endtask

    task automatic test_full_overflow();
        do_push(2'b10);
        do_push(2'b01);
        do_push(2'b11);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fo_full_at7 got=%b exp=0", full); end
        do_push(2'b00);
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fo_full got=%b exp=1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fo_ovf_early got=%b exp=0", overflow); end
        do_push(2'b10);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fo_ovf_set got=%b exp=1", overflow); end
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fo_ovf_sticky got=%b exp=1", overflow); end
        do_pop();
        checks++; if (pop_val !== 2'b00) begin errors++; $display("FAIL fo_top_intact got=%b exp=00", pop_val); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL fo_not_full got=%b exp=0", full); end
        // Simultaneous push and pop: push only.
        push = 1'b1; push_val = 2'b01; pop = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0;
        checks++; if (pop_val !== 2'b00) begin errors++; $display("FAIL fo_pp_pop_val got=%b exp=00", pop_val); end
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fo_pp_full got=%b exp=1", full); end
        do_pop();
        checks++; if (pop_val !== 2'b01) begin errors++; $display("FAIL fo_pp_pushed got=%b exp=01", pop_val); end
    endtask

    task automatic test_rewind_and_reset();
        ld_q = 1'b1;
        tick();
        ld_q = 1'b0;
        dequeue = 1'b1;
        tick();
        tick();
        checks++; if (deq_val !== 2'b01) begin errors++; $display("FAIL rw_second got=%b exp=01", deq_val); end
        rst_frontq = 1'b1;
        tick();
        rst_frontq = 1'b0;
        checks++;
        if (deq_valid !== 1'b0 || deq_val !== 2'b01) begin
            errors++; $display("FAIL rw_rewind_no_read got=%b/%b exp=01/0", deq_val, deq_valid);
        end
        tick();
        dequeue = 1'b0;
        checks++;
        if (deq_val !== 2'b00 || deq_valid !== 1'b1) begin
            errors++; $display("FAIL rw_after_rewind got=%b/%b exp=00/1", deq_val, deq_valid);
        end
        // ld_q with dequeue: rewinds, no read.
        ld_q = 1'b1; dequeue = 1'b1;
        tick();
        ld_q = 1'b0; dequeue = 1'b0;
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL rw_ldq_deq got=%b exp=0", deq_valid); end
        dequeue = 1'b1;
        tick();
        dequeue = 1'b0;
        checks++;
        if (deq_val !== 2'b00 || deq_valid !== 1'b1) begin
            errors++; $display("FAIL rw_ldq_first got=%b/%b exp=00/1", deq_val, deq_valid);
        end
        // Reset mid-replay, with commands also asserted.
        rst = 1'b1; dequeue = 1'b1; push = 1'b1; push_val = 2'b11;
        tick();
        rst = 1'b0; dequeue = 1'b0; push = 1'b0;
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rr_empty got=%b exp=1", empty); end
        checks++; if (finishq !== 1'b1)   begin errors++; $display("FAIL rr_finishq got=%b exp=1", finishq); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rr_overflow got=%b exp=0", overflow); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL rr_deq_valid got=%b exp=0", deq_valid); end
        checks++; if (deq_val !== 2'b00)  begin errors++; $display("FAIL rr_deq_val got=%b exp=00", deq_val); end
        checks++; if (pop_val !== 2'b00)  begin errors++; $display("FAIL rr_pop_val got=%b exp=00", pop_val); end
        dequeue = 1'b1;
        tick();
        dequeue = 1'b0;
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL rr_empty_path_deq got=%b exp=0", deq_valid); end
    endtask

`ifdef PATH_STACK_LEN_EN
    task automatic test_len();
        for (int i = 0; i < 5; i++) do_push(2'(i));
        do_pop();
        do_pop();
        do_push(2'b11);
        ld_q = 1'b1;
        tick();
        ld_q = 1'b0;
        checks++; if (path_len !== PW'(4))  begin errors++; $display("FAIL len_path_len got=%0d exp=4", path_len); end
        checks++; if (max_depth !== PW'(5)) begin errors++; $display("FAIL len_max_depth got=%0d exp=5", max_depth); end
    endtask
`endif

    initial begin
        test_reset();
        test_push_pop();
        test_pop_empty();
        test_replay();
        test_full_overflow();
        test_rewind_and_reset();
`ifdef PATH_STACK_LEN_EN
        test_len();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
